// File: rtl/prio_enc_q.sv
// ---------------------------------------------------------------------------
// prio_enc_q -- registered N-input priority encoder with request queueing.
//
// Incoming request bits are merged into a pending vector so that no request
// is lost while a granted result waits on the consumer. Each grant is
// presented through a valid/ready handshake with a fully registered output.
//
// Policy:
//   - Fixed priority: the highest set index of (pend | req) wins.
//   - Round-robin: compiled in only when the macro PRIO_ENC_RR_EN is
//     defined. The search starts just below the last granted index and
//     wraps. Without the macro the mode port is accepted but ignored.
//
// Parameters:
//   N  number of request inputs (>= 2)
//   W  width of the encoded index, $clog2(N)
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   req         in   [N-1:0] request bits, sampled every edge
//   mode        in   0 = fixed priority, 1 = round-robin (if compiled in)
//   out_ready   in   consumer accepts the presented result
//   out_valid   out  out_idx / out_onehot hold a valid result
//   out_idx     out  [W-1:0] index of the granted request
//   out_onehot  out  [N-1:0] one-hot form of out_idx
//   pend        out  [N-1:0] latched requests not yet granted
//   ovf         out  sticky: a request hit a bit that was already pending
// ---------------------------------------------------------------------------
module prio_enc_q #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic [N-1:0] pend,
  output logic         ovf
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_idx_q,   out_idx_d;
  logic [N-1:0] out_onehot_q, out_onehot_d;
  logic [N-1:0] pend_q,      pend_d;
  logic         ovf_q,       ovf_d;

  // -------------------------------------------------------------------------
  // Candidate set and load condition
  // -------------------------------------------------------------------------
  logic [N-1:0] cand;
  logic         cand_any;
  logic         slot_free;
  logic         load;

  assign cand      = pend_q | req;
  assign cand_any  = |cand;
  // The output slot can take a new result when it is empty or being drained
  // this very edge, which gives back-to-back grants with no bubble.
  assign slot_free = !out_valid_q || out_ready;
  assign load      = slot_free && cand_any;

  // -------------------------------------------------------------------------
  // Fixed-priority selection: ascending scan, so the highest set bit is the
  // last one written and wins.
  // -------------------------------------------------------------------------
  logic [W-1:0] fix_sel;

  always_comb begin
    fix_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (cand[i]) begin
        fix_sel = W'(i);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Final selection (optionally round-robin)
  // -------------------------------------------------------------------------
  logic [W-1:0] sel;

`ifdef PRIO_ENC_RR_EN
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] rr_sel;
  int           rr_best;
  int           rr_dist;

  // Each index gets a search distance from ptr: ptr-1 is distance 1, the
  // search runs downward and wraps, and ptr itself is checked last
  // (distance N). The set candidate with the smallest distance wins.
  always_comb begin
    rr_sel  = '0;
    rr_best = N + 1;
    rr_dist = 0;
    for (int i = 0; i < N; i++) begin
      rr_dist = int'(ptr_q) - i;
      if (rr_dist <= 0) begin
        rr_dist = rr_dist + N;
      end
      if (cand[i] && (rr_dist < rr_best)) begin
        rr_best = rr_dist;
        rr_sel  = W'(i);
      end
    end
  end

  assign sel = mode ? rr_sel : fix_sel;

  // The pointer follows every grant regardless of mode, so switching to
  // round-robin resumes just below the most recent grant.
  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority only; mode is accepted on the port but has no effect.
  logic unused_mode;
  assign unused_mode = mode;
  assign sel         = fix_sel;
`endif

  // -------------------------------------------------------------------------
  // One-hot decode of the selected index
  // -------------------------------------------------------------------------
  logic [N-1:0] sel_onehot;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
      assign sel_onehot[gi] = (sel == W'(gi));
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    out_valid_d  = out_valid_q;
    out_idx_d    = out_idx_q;
    out_onehot_d = out_onehot_q;
    pend_d       = cand;
    // A request landing on a bit that is already latched cannot be counted
    // twice; flag it and keep the flag until reset.
    ovf_d        = ovf_q || ((req & pend_q) != '0);

    if (load) begin
      out_valid_d  = 1'b1;
      out_idx_d    = sel;
      out_onehot_d = sel_onehot;
      // The granted bit is consumed even when it arrived on req this edge.
      pend_d       = cand & ~sel_onehot;
    end else if (out_valid_q && out_ready) begin
      // Drained with nothing left to present; index/one-hot keep last value.
      out_valid_d = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_onehot_q <= '0;
      pend_q       <= '0;
      ovf_q        <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_idx_q    <= out_idx_d;
      out_onehot_q <= out_onehot_d;
      pend_q       <= pend_d;
      ovf_q        <= ovf_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign out_valid  = out_valid_q;
  assign out_idx    = out_idx_q;
  assign out_onehot = out_onehot_q;
  assign pend       = pend_q;
  assign ovf        = ovf_q;

endmodule

// File: doc/prio_enc_q.md
# prio_enc_q

Registered, parametrised priority encoder with request queueing, for the peripheral interrupt/request path. It generalises the team's 4-input combinational encoder to N inputs and latches requests into a pending vector, so no request is lost while a result waits. Each result is presented through a valid/ready handshake. Fixed-priority (highest index wins) is always available; round-robin is optional at compile time.

## Interface
- N, default 8: number of request inputs; must be at least 2.
- W, default $clog2(N): width of the encoded index.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  request bits, sampled every clk edge; a pulse or a level both register.
- mode  input  1  0 = fixed priority, 1 = round-robin (only when PRIO_ENC_RR_EN is defined).
- out_ready  input  1  consumer accepts the current result.
- out_valid  output  1  out_idx / out_onehot hold a valid result.
- out_idx  output  W  encoded index of the granted request.
- out_onehot  output  N  one-hot form of out_idx.
- pend  output  N  pending (latched, not yet granted) request vector.
- ovf  output  1  sticky flag: a request arrived on a bit that was already pending.

## Operation
- Reset values: out_valid=0, out_idx=0, out_onehot=0, pend=0, ovf=0, rr pointer=0.
- Candidate set: cand = pend | req.
- Load condition: load = (!out_valid || out_ready) && (cand != 0).
- On load:
  - out_idx gets the selected index and out_onehot = 1<<idx.
  - out_valid is set to 1.
  - The selected bit is cleared: pend_next = cand & ~onehot(sel).
- Without load: pend_next = cand.
- If out_valid && out_ready && cand==0: out_valid goes to 0. out_idx and out_onehot keep their last values.
- Fixed priority (mode=0): sel is the highest set index of cand.
- Round-robin (mode=1): the search starts at ptr-1 and moves downward, wrapping from 0 to N-1. The last index checked is ptr. On every load, ptr takes the selected index.
  - At reset ptr=0, so the first search begins at N-1, identical to fixed priority.
- ovf sets on any edge where (req & pend) != 0. It is cleared only by reset.
- Simultaneous events:
  - A req bit that is selected in the same cycle is consumed by that grant and is not left pending.
  - A req on a bit equal to the currently presented out_idx is a new request and becomes pending.
- The output register holds stable while out_valid && !out_ready.

## Timing
- Latency: a req sampled at edge k, with the output slot free, gives out_valid=1 after edge k (one cycle, registered output).
- Throughput: one grant per cycle while out_ready=1 and cand!=0.
- Back-to-back: out_ready high at edge k with cand!=0 loads the next result at the same edge. There is no bubble.
- Reset mid-operation: all state clears immediately. Pending requests are dropped and are not re-presented.
- Changing mode takes effect on the next selection. ptr is retained across mode changes.

## Configuration
- PRIO_ENC_RR_EN defined:
  - The round-robin pointer and rotate-search logic are compiled in.
  - mode selects the policy as described in Operation.
- PRIO_ENC_RR_EN undefined:
  - The pointer register and rotate logic are absent.
  - The mode port remains but is ignored; the block is always fixed priority.

## Test plan
- Reset check: assert rst_n=0 mid-stream with pend=8'h5A and out_valid=1. Expect all outputs 0 at once; after release with req=0, out_valid stays 0.
- Fixed priority, N=8, mode=0, out_ready=1: one-cycle pulse req=8'b1001_0010.
  - Expect out_idx 7, 4, 1 on consecutive cycles.
  - Expect pend 8'h12, 8'h02, 8'h00 in those cycles.
  - out_valid then drops.
- Backpressure: out_ready=0 with a req pulse of 8'h01, then a pulse of 8'h80.
  - Expect out_idx=0 held stable and pend=8'h80.
  - Raising out_ready gives out_idx=7 the next cycle.
- Overflow: hold req=8'h04 for 3 cycles with out_ready=0. Expect ovf=1 from the third edge on, staying 1 after req drops.
- Round-robin (PRIO_ENC_RR_EN defined), mode=1, out_ready=1: hold req=8'b1010_0001 constant.
  - Expect out_idx sequence 7, 5, 0, 7, 5, 0.
  - With mode=0 the same stimulus gives 7 every cycle.
- Same-cycle re-request:
  - While out_idx=3 is held (out_ready=0), pulse req=8'h08. Expect pend=8'h08.
  - After out_ready goes high, out_idx=3 appears again the next cycle.
